alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
// Parametrised, pipelined integer/branch execution unit for the OOO core; successor of the single-cycle ALU.
// Sits between the issue queue and the CDB/ROB; accepts one uop per cycle (valid/ready), result after STAGES cycles.
// Resolves branches against the front-end prediction; flags mispredict only on a real miss.
// Supports backpressure, global flush, and saturating branch/mispredict performance counters.
// PARAMETERS
// XLEN     32  datapath width (operands, pc, imm, result)
// ROB_W    3   ROB index width
// PREG_W   7   destination physical register tag width
// STAGES   2   register stages from input to output, legal 1..4
// CNT_W    32  performance counter width
// PORTS
// clk            in   1       clock, rising edge
// rst_n          in   1       asynchronous active-low reset
// flush_i        in   1       kill every in-flight uop (ROB-driven recovery)
// i_valid        in   1       uop presented
// i_ready        out  1       unit accepts uop this cycle
// i_opcode       in   5       opcode[6:2], shared opcode defines
// i_funct3       in   3       funct3
// i_funct7       in   1       instr[30]
// i_rs1/i_rs2    in   XLEN    source operands
// i_imm/i_pc     in   XLEN    immediate, uop pc
// i_rob_idx      in   ROB_W   ROB tag
// i_rd           in   PREG_W  dest tag
// i_pred_taken   in   1       front-end predicted taken
// i_pred_target  in   XLEN    front-end predicted target (valid if pred_taken)
// o_valid        out  1       result beat
// o_ready        in   1       consumer (CDB arbiter) takes beat
// o_rob_idx/o_rd out  ROB_W/PREG_W  tags of the beat
// o_data         out  XLEN    result (pc+4 for JAL/JALR, 0 for branches)
// o_wb           out  1       beat writes o_rd (0 for B_TYPE)
// o_br           out  1       beat is JAL/JALR/B_TYPE
// o_taken        out  1       actual control-flow taken
// o_mispredict   out  1       redirect required; qualified by o_valid
// o_redirect_pc  out  XLEN    correct next pc when o_mispredict
// perf_br_cnt    out  CNT_W   resolved control-flow uops
// perf_mp_cnt    out  CNT_W   mispredicts
// BEHAVIOUR
// - Reset: all stage valid bits 0, o_valid 0, all other outputs 0, counters 0; i_ready 1 after reset.
// - Compute in stage 0 combinationally (RV32I ALU ops, SUB/SRA via funct7, I_TYPE uses imm, LUI, AUIPC, JAL, JALR, B_TYPE compares);
//   result and resolution registered into stage 1, carried through STAGES-1 further registers; o_* driven from last stage.
// - Shift amount = operand2[4:0] (log2(XLEN) bits); all arithmetic mod 2^XLEN; JALR target bit0 cleared.
// - Handshake: stage k advances when empty or stage k+1 advances; last stage advances when o_ready.
//   i_ready = stage1 advances. Bubbles collapse. o_* stable while o_valid && !o_ready. No comb path i_valid->o_valid.
// - Taken: JAL/JALR always; B_TYPE per compare; else 0. Actual next = taken ? target : pc+4.
// - Mispredict = o_br && (taken != pred_taken || (taken && target != pred_target)); redirect_pc = actual next.
//   Not-taken branch predicted not-taken: no mispredict, pred_target ignored. Non-branch: mispredict 0.
// - flush_i: every stage valid cleared at the next edge incl. last stage; uop at input that cycle is dropped;
//   i_ready may stay 1 but acceptance during flush is void. Flush wins over simultaneous o_ready.
// - Counters increment once per beat on o_valid && o_ready && o_br (mp when also o_mispredict); saturate at all-ones.
// - Unknown opcode: o_data 0, o_wb 1, o_br 0 (decode prevents).
// - Reset mid-operation: asynchronously clears all valids and counters; no beat emitted after release until new input.
// TESTING
// - STAGES=2, ADD rs1=5 rs2=7 accepted cycle 0 -> o_valid cycle 2, o_data=12, o_wb=1, o_br=0.
// - SUB 3-5 -> 0xFFFFFFFE; SRA 0x80000000>>>4 -> 0xF8000000; SLTU 1<0xFFFFFFFF -> 1.
// - BEQ equal, pc=0x100 imm=0x20, pred_taken=0 -> o_mispredict=1, redirect 0x120, o_wb=0; same with pred_taken=1 target 0x120 -> mispredict 0.
// - Hold o_ready=0 for 5 cycles with back-to-back input -> exactly STAGES uops buffered, i_ready 0, no loss/dup, order kept.
// - flush_i with 2 uops in flight and o_ready=1 -> no o_valid following, counters unchanged.
// - CNT_W=4, 20 mispredicting JAL beats -> perf_br_cnt=perf_mp_cnt=15; rst_n low mid-stream -> all zero asynchronously.

Source files
------------

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - issue-side uop and CDB-side result bundle for alu_pipe
interface alu_pipe_if #(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 3,
    parameter int PREG_W = 7
);
    logic              i_valid;
    logic              i_ready;
    logic [4:0]        i_opcode;
    logic [2:0]        i_funct3;
    logic              i_funct7;
    logic [XLEN-1:0]   i_rs1;
    logic [XLEN-1:0]   i_rs2;
    logic [XLEN-1:0]   i_imm;
    logic [XLEN-1:0]   i_pc;
    logic [ROB_W-1:0]  i_rob_idx;
    logic [PREG_W-1:0] i_rd;
    logic              i_pred_taken;
    logic [XLEN-1:0]   i_pred_target;

    logic              o_valid;
    logic              o_ready;
    logic [ROB_W-1:0]  o_rob_idx;
    logic [PREG_W-1:0] o_rd;
    logic [XLEN-1:0]   o_data;
    logic              o_wb;
    logic              o_br;
    logic              o_taken;
    logic              o_mispredict;
    logic [XLEN-1:0]   o_redirect_pc;

    modport master (
        output i_valid, i_opcode, i_funct3, i_funct7, i_rs1, i_rs2, i_imm, i_pc,
               i_rob_idx, i_rd, i_pred_taken, i_pred_target, o_ready,
        input  i_ready, o_valid, o_rob_idx, o_rd, o_data, o_wb, o_br, o_taken,
               o_mispredict, o_redirect_pc
    );

    modport slave (
        input  i_valid, i_opcode, i_funct3, i_funct7, i_rs1, i_rs2, i_imm, i_pc,
               i_rob_idx, i_rd, i_pred_taken, i_pred_target, o_ready,
        output i_ready, o_valid, o_rob_idx, o_rd, o_data, o_wb, o_br, o_taken,
               o_mispredict, o_redirect_pc
    );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined integer/branch execution unit with flush and perf counters
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int ROB_W  = 3,
    parameter int PREG_W = 7,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    alu_pipe_if.slave        io,
    output logic [CNT_W-1:0] perf_br_cnt,
    output logic [CNT_W-1:0] perf_mp_cnt
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [PREG_W-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              wb;
        logic              br;
        logic              taken;
        logic              mispredict;
        logic [XLEN-1:0]   redirect_pc;
    } beat_t;

    logic              is_rr;
    logic              br_cond;
    logic [XLEN-1:0]   op2;
    logic [SH_W-1:0]   shamt;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   target;
    beat_t             s0;

    always_comb begin
        is_rr    = (io.i_opcode == OPC_OP);
        op2      = is_rr ? io.i_rs2 : io.i_imm;
        shamt    = op2[SH_W-1:0];
        alu_res  = '0;
        case (io.i_funct3)
            3'b000: alu_res = (is_rr && io.i_funct7) ? io.i_rs1 - op2 : io.i_rs1 + op2;
            3'b001: alu_res = io.i_rs1 << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(io.i_rs1) < $signed(op2))};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, (io.i_rs1 < op2)};
            3'b100: alu_res = io.i_rs1 ^ op2;
            3'b101: begin
                // kept as separate statements so the arithmetic shift stays signed
                if (io.i_funct7) alu_res = $signed(io.i_rs1) >>> shamt;
                else             alu_res = io.i_rs1 >> shamt;
            end
            3'b110: alu_res = io.i_rs1 | op2;
            default: alu_res = io.i_rs1 & op2;
        endcase

        case (io.i_funct3)
            3'b000:  br_cond = (io.i_rs1 == io.i_rs2);
            3'b001:  br_cond = (io.i_rs1 != io.i_rs2);
            3'b100:  br_cond = ($signed(io.i_rs1) <  $signed(io.i_rs2));
            3'b101:  br_cond = ($signed(io.i_rs1) >= $signed(io.i_rs2));
            3'b110:  br_cond = (io.i_rs1 <  io.i_rs2);
            3'b111:  br_cond = (io.i_rs1 >= io.i_rs2);
            default: br_cond = 1'b0;
        endcase

        pc_plus4   = io.i_pc + XLEN'(4);
        target     = io.i_pc + io.i_imm;
        s0         = '0;
        s0.rob_idx = io.i_rob_idx;
        s0.rd      = io.i_rd;
        s0.wb      = 1'b1;
        case (io.i_opcode)
            OPC_OP, OPC_OP_IMM: s0.data = alu_res;
            OPC_LUI:            s0.data = io.i_imm;
            OPC_AUIPC:          s0.data = target;
            OPC_JAL: begin
                s0.br    = 1'b1;
                s0.taken = 1'b1;
                s0.data  = pc_plus4;
            end
            OPC_JALR: begin
                target   = (io.i_rs1 + io.i_imm) & {{(XLEN-1){1'b1}}, 1'b0};
                s0.br    = 1'b1;
                s0.taken = 1'b1;
                s0.data  = pc_plus4;
            end
            OPC_BRANCH: begin
                s0.br    = 1'b1;
                s0.wb    = 1'b0;
                s0.taken = br_cond;
            end
            default: ;
        endcase
        s0.redirect_pc = s0.taken ? target : pc_plus4;
        // predicted target only matters when the branch really is taken
        s0.mispredict  = s0.br && ((s0.taken != io.i_pred_taken) ||
                                   (s0.taken && (target != io.i_pred_target)));
    end

    beat_t             pipe [STAGES];
    beat_t             feed [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vld_feed;
    logic [STAGES-1:0] adv;

    always_comb begin
        feed[0]     = s0;
        vld_feed[0] = io.i_valid;
        for (int k = 1; k < STAGES; k++) begin
            feed[k]     = pipe[k-1];
            vld_feed[k] = vld[k-1];
        end
    end

    // a stage moves when the consumer takes the head or any stage from here to the head is empty
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = io.o_ready || !(&vld[STAGES-1:k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush_i)     vld[k] <= 1'b0;
                else if (adv[k]) vld[k] <= vld_feed[k];
                if (adv[k])      pipe[k] <= feed[k];
            end
        end
    end

    logic beat_fire;
    assign beat_fire = vld[STAGES-1] && io.o_ready && !flush_i && pipe[STAGES-1].br;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt <= '0;
            perf_mp_cnt <= '0;
        end else if (beat_fire) begin
            if (perf_br_cnt != '1) perf_br_cnt <= perf_br_cnt + CNT_W'(1);
            if (pipe[STAGES-1].mispredict && (perf_mp_cnt != '1))
                perf_mp_cnt <= perf_mp_cnt + CNT_W'(1);
        end
    end

    assign io.i_ready       = adv[0];
    assign io.o_valid       = vld[STAGES-1];
    assign io.o_rob_idx     = pipe[STAGES-1].rob_idx;
    assign io.o_rd          = pipe[STAGES-1].rd;
    assign io.o_data        = pipe[STAGES-1].data;
    assign io.o_wb          = pipe[STAGES-1].wb;
    assign io.o_br          = pipe[STAGES-1].br;
    assign io.o_taken       = pipe[STAGES-1].taken;
    assign io.o_mispredict  = pipe[STAGES-1].mispredict;
    assign io.o_redirect_pc = pipe[STAGES-1].redirect_pc;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized scoreboard bench for alu_pipe with directed literal checks
module tb_alu_pipe;
    localparam int XLEN = 32, ROB_W = 3, PREG_W = 7, STAGES = 2, CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [4:0] OP = 5'b01100, OPI = 5'b00100, LUI = 5'b01101, AUIPC = 5'b00101;
    localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, BR = 5'b11000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [CNT_W-1:0] br_cnt, mp_cnt;
    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(XLEN), .ROB_W(ROB_W), .PREG_W(PREG_W)) bus ();

    alu_pipe #(.XLEN(XLEN), .ROB_W(ROB_W), .PREG_W(PREG_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .io(bus),
        .perf_br_cnt(br_cnt), .perf_mp_cnt(mp_cnt)
    );

    typedef struct {
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] rd;
        logic [31:0]       data;
        logic              wb, br, taken, mp;
        logic [31:0]       redirect;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   m_br = 0, m_mp = 0;
    logic [4:0] ops [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] r;
        sh = int'(b % 32);
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a >> sh;
                if (alt && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic exp_t model(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                   input logic [31:0] pc, input logic [ROB_W-1:0] rob,
                                   input logic [PREG_W-1:0] rd, input logic pt, input logic [31:0] ptgt);
        exp_t e;
        logic [31:0] tgt;
        e.rob = rob; e.rd = rd; e.data = 0; e.wb = 1; e.br = 0; e.taken = 0;
        tgt = pc + imm;
        case (op)
            OP:    e.data = alu(f3, f7, a, b);
            OPI:   e.data = alu(f3, (f3 == 3'd5) && f7, a, imm);
            LUI:   e.data = imm;
            AUIPC: e.data = pc + imm;
            JAL:   begin e.br = 1; e.taken = 1; e.data = pc + 4; end
            JALR:  begin e.br = 1; e.taken = 1; e.data = pc + 4; tgt = (a + imm) & 32'hFFFF_FFFE; end
            BR: begin
                e.br = 1; e.wb = 0;
                case (f3)
                    3'd0: e.taken = (a == b);
                    3'd1: e.taken = (a != b);
                    3'd4: e.taken = int'(a) < int'(b);
                    3'd5: e.taken = int'(a) >= int'(b);
                    3'd6: e.taken = a < b;
                    3'd7: e.taken = a >= b;
                    default: e.taken = 0;
                endcase
            end
            default: ;
        endcase
        e.redirect = e.taken ? tgt : pc + 4;
        e.mp = e.br && ((e.taken != pt) || (e.taken && tgt != ptgt));
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete(); m_br = 0; m_mp = 0;
        end else begin
            check("perf_br_cnt", br_cnt, m_br);
            check("perf_mp_cnt", mp_cnt, m_mp);
            if (bus.o_valid) begin
                if (q.size() == 0) check("spurious_o_valid", 1, 0);
                else begin
                    check("beat_data", bus.o_data, q[0].data);
                    check("beat_wb", bus.o_wb, q[0].wb);
                    check("beat_br", bus.o_br, q[0].br);
                    check("beat_taken", bus.o_taken, q[0].taken);
                    check("beat_mispredict", bus.o_mispredict, q[0].mp);
                    check("beat_rob_idx", bus.o_rob_idx, q[0].rob);
                    check("beat_rd", bus.o_rd, q[0].rd);
                    if (q[0].mp) check("beat_redirect", bus.o_redirect_pc, q[0].redirect);
                end
            end
            if (flush) q.delete();
            else begin
                if (bus.o_valid && bus.o_ready && q.size() > 0) begin
                    if (q[0].br) m_br = (m_br == CNT_MAX) ? CNT_MAX : m_br + 1;
                    if (q[0].mp) m_mp = (m_mp == CNT_MAX) ? CNT_MAX : m_mp + 1;
                    void'(q.pop_front());
                end
                if (bus.i_valid && bus.i_ready)
                    q.push_back(model(bus.i_opcode, bus.i_funct3, bus.i_funct7, bus.i_rs1, bus.i_rs2,
                                      bus.i_imm, bus.i_pc, bus.i_rob_idx, bus.i_rd,
                                      bus.i_pred_taken, bus.i_pred_target));
            end
        end
    end

    task automatic set_uop(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [ROB_W-1:0] rob, input logic pt,
                           input logic [31:0] ptgt);
        bus.i_opcode = op; bus.i_funct3 = f3; bus.i_funct7 = f7;
        bus.i_rs1 = a; bus.i_rs2 = b; bus.i_imm = imm; bus.i_pc = pc;
        bus.i_rob_idx = rob; bus.i_rd = {4'd0, rob} + 7'd40;
        bus.i_pred_taken = pt; bus.i_pred_target = ptgt;
    endtask

    task automatic rand_uop();
        logic [4:0]  op;
        logic [31:0] a, b, imm, pc, tgt;
        op  = ops[$urandom_range(0, 8)];
        a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom();
        pc  = $urandom() & 32'hFFFF_FFFC;
        tgt = (op == JALR) ? ((a + imm) & 32'hFFFF_FFFE) : pc + imm;
        set_uop(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b, imm, pc,
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 0) ? tgt : $urandom());
    endtask

    task automatic run_one(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                           output exp_t got);
        int t;
        set_uop(op, f3, f7, a, b, imm, pc, 3'd5, pt, ptgt);
        bus.i_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.i_ready && t < 20) begin @(negedge clk); t++; end
        check("accept_in_time", t < 20, 1);
        @(posedge clk); #1 bus.i_valid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus.o_valid && t < 20) begin @(negedge clk); t++; end
        check("beat_in_time", t < 20, 1);
        got.data = bus.o_data; got.wb = bus.o_wb; got.br = bus.o_br; got.taken = bus.o_taken;
        got.mp = bus.o_mispredict; got.redirect = bus.o_redirect_pc;
        got.rob = bus.o_rob_idx; got.rd = bus.o_rd;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t g;
        int acc, rec_br, rec_mp;
        ops = '{OP, OPI, LUI, AUIPC, JAL, JALR, BR, 5'b00000, 5'b11100};
        bus.i_valid = 1'b0; bus.o_ready = 1'b1;
        set_uop(OP, 3'd0, 1'b0, 0, 0, 0, 0, 3'd0, 1'b0, 0);

        @(negedge clk);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_i_ready", bus.i_ready, 1);
        check("rst_o_data", bus.o_data, 0);
        check("rst_br_cnt", br_cnt, 0);
        check("rst_mp_cnt", mp_cnt, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        set_uop(OP, 3'd0, 1'b0, 5, 7, 0, 32'h40, 3'd2, 1'b0, 0);
        bus.i_valid = 1'b1;
        @(negedge clk); check("add_i_ready", bus.i_ready, 1);
        @(posedge clk); #1 bus.i_valid = 1'b0;
        check("add_o_valid_c1", bus.o_valid, 0);
        @(posedge clk); #1;
        check("add_o_valid_c2", bus.o_valid, 1);
        check("add_data", bus.o_data, 12);
        check("add_wb", bus.o_wb, 1);
        check("add_br", bus.o_br, 0);
        @(posedge clk); #1;

        run_one(OP, 3'd0, 1'b1, 3, 5, 0, 32'h200, 1'b0, 0, g);
        check("sub_data", g.data, 32'hFFFF_FFFE);
        run_one(OP, 3'd5, 1'b1, 32'h8000_0000, 4, 0, 32'h204, 1'b0, 0, g);
        check("sra_data", g.data, 32'hF800_0000);
        run_one(OP, 3'd3, 1'b0, 1, 32'hFFFF_FFFF, 0, 32'h208, 1'b0, 0, g);
        check("sltu_data", g.data, 1);
        run_one(BR, 3'd0, 1'b0, 9, 9, 32'h20, 32'h100, 1'b0, 0, g);
        check("beq_mp", g.mp, 1);
        check("beq_redirect", g.redirect, 32'h120);
        check("beq_wb", g.wb, 0);
        run_one(BR, 3'd0, 1'b0, 9, 9, 32'h20, 32'h100, 1'b1, 32'h120, g);
        check("beq_pred_ok_mp", g.mp, 0);
        check("beq_pred_ok_taken", g.taken, 1);

        for (int i = 0; i < 1500; i++) begin
            bus.o_ready = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 49) == 0);
            bus.i_valid = ($urandom_range(0, 3) != 0);
            rand_uop();
            @(posedge clk); #1;
        end
        flush = 1'b0; bus.i_valid = 1'b0; bus.o_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("random_drained", q.size(), 0);

        bus.o_ready = 1'b0; acc = 0;
        for (int i = 0; i < 5; i++) begin
            set_uop(OPI, 3'd0, 1'b0, 32'(i * 100), 0, 32'(i), 0, 3'(i), 1'b0, 0);
            bus.i_valid = 1'b1;
            @(negedge clk); if (bus.i_ready) acc++;
            @(posedge clk); #1;
        end
        check("bp_buffered", acc, STAGES);
        check("bp_i_ready", bus.i_ready, 0);
        check("bp_queue", q.size(), STAGES);
        bus.i_valid = 1'b0; bus.o_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("bp_drained", q.size(), 0);

        set_uop(JAL, 3'd0, 1'b0, 0, 0, 32'h10, 32'h300, 3'd1, 1'b0, 0);
        bus.i_valid = 1'b1;
        @(posedge clk); #1 bus.i_rob_idx = 3'd2;
        @(posedge clk); #1;
        flush = 1'b1; bus.i_rob_idx = 3'd3;
        rec_br = int'(br_cnt); rec_mp = int'(mp_cnt);
        @(posedge clk); #1 flush = 1'b0; bus.i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_o_valid", bus.o_valid, 0);
            check("flush_br_cnt", br_cnt, rec_br);
            check("flush_mp_cnt", mp_cnt, rec_mp);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            set_uop(JAL, 3'd0, 1'b0, 0, 0, 32'h40, 32'(32'h1000 + i * 4), 3'(i), 1'b0, 0);
            bus.i_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sat_br_cnt", br_cnt, 15);
        check("sat_mp_cnt", mp_cnt, 15);

        for (int i = 0; i < 4; i++) begin
            set_uop(JAL, 3'd0, 1'b0, 0, 0, 32'h40, 32'h2000, 3'(i), 1'b0, 0);
            bus.i_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_br_cnt", br_cnt, 0);
        check("async_rst_mp_cnt", mp_cnt, 0);
        check("async_rst_o_valid", bus.o_valid, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_idle", bus.o_valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
